// File: rtl/div_unit.sv
// Iterative restoring divider feeding the HI/LO register pair.
// Produces one quotient bit per cycle and issues a single-cycle HI/LO write on completion.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, quotient shifts in at the LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   shifted;
  logic             qbit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    // Trial subtraction on the (WIDTH+1)-bit shifted remainder; when it succeeds the
    // difference is below the divisor, so the low WIDTH bits hold it exactly.
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    qbit     = (shifted >= {1'b0, dvs_q});
    rem_step = qbit ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    quo_step = {dvd_q[WIDTH-2:0], qbit};

    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    ready_d   = 1'b0;
    hi_d      = '0;
    lo_d      = '0;

    unique case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          dvd_d     = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
          dvs_d     = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
          rem_d     = '0;
          cnt_d     = '0;
          quo_neg_d = signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          rem_neg_d = signed_i && opdata1_i[WIDTH-1];
          state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d = S_END;
          ready_d = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            cnt_d   = '0;
            state_d = S_END;
            ready_d = 1'b1;
            lo_d    = quo_neg_q ? -quo_step : quo_step;
            hi_d    = rem_neg_q ? -rem_step : rem_step;
          end
        end
      end
      S_END: begin
        state_d = S_FREE;
      end
      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      ready_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      ready_q   <= ready_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Result registers are loaded only on entry to END, so they read zero at all other times.
  assign busy_o    = (state_q != S_FREE);
  assign ready_o   = ready_q;
  assign hilo_we_o = ready_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected HI/LO and completion cycle are queued at issue
// and checked by an independent monitor whenever the divider presents a write.
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         signed_i;
  logic         annul_i;
  logic [W-1:0] opdata1_i;
  logic [W-1:0] opdata2_i;
  logic         busy_o;
  logic         ready_o;
  logic         hilo_we_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .annul_i   (annul_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           at;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle number as the divider sees it: cycle 0 is the one whose closing edge accepts start.
  function automatic int now();
    return cyc + 1;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, now());
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int acc);
    exp_t   e;
    longint sa, sd, q, r;
    if (b == '0) begin
      e.hi = '0;
      e.lo = '0;
      e.at = acc + 2;
    end else begin
      e.at = acc + W + 1;
      if (s) begin
        sa   = longint'(signed'(a));
        sd   = longint'(signed'(b));
        q    = sa / sd;
        r    = sa % sd;
        e.lo = q[W-1:0];
        e.hi = r[W-1:0];
      end else begin
        e.lo = a / b;
        e.hi = a % b;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1) begin
      chk("we_eq_ready", {31'b0, hilo_we_o}, {31'b0, ready_o});
      if (ready_o) begin
        if (scb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got hi=%h lo=%h required no write (cycle %0d)",
                   hi_o, lo_o, now());
        end else begin
          e = scb.pop_front();
          chk("lo", lo_o, e.lo);
          chk("hi", hi_o, e.hi);
          chk("latency", now(), e.at);
        end
      end else begin
        chk("hi_idle", hi_o, '0);
        chk("lo_idle", lo_o, '0);
      end
    end
  end

  task automatic wait_free();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      checks++;
      errors++;
      $display("FAIL timeout_busy: got busy=1 required 0 within 200 cycles");
    end
  endtask

  // Called at a negedge with the divider free; returns one negedge later (op cycle 1).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit push, output int acc);
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    acc       = now();
    if (push) scb.push_back(model(a, b, s, acc));
    @(negedge clk);
    start_i   = 1'b0;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_i  = $urandom_range(0, 1);
    chk("busy_after_accept", {31'b0, busy_o}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int acc);
    wait_free();
    issue(a, b, s, 1'b1, acc);
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (now() < target && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (scb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_drain: got %0d pending results required 0", scb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           acc;
    logic [W-1:0] a, b;
    logic         s;

    rst       = 1'b0;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy_o}, '0);
    chk("rst_ready", {31'b0, ready_o}, '0);
    chk("rst_we", {31'b0, hilo_we_o}, '0);
    chk("rst_hi", hi_o, '0);
    chk("rst_lo", lo_o, '0);
    rst = 1'b1;
    @(negedge clk);

    // DIVU 100/7, with a start pulse while busy that must be ignored
    run_op(32'd100, 32'd7, 1'b0, acc);
    wait_until(acc + 5);
    start_i   = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    drain();

    // DIV -7 / 2
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, acc);
    drain();

    // Divide by zero, then busy must be low in op cycle 3
    run_op(32'h1234_5678, 32'd0, 1'b0, acc);
    wait_until(acc + 3);
    chk("byzero_busy_c3", {31'b0, busy_o}, '0);

    // Annul in cycle 10, restart in the first free cycle
    wait_free();
    issue(32'd100, 32'd7, 1'b0, 1'b0, acc);
    wait_until(acc + 10);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy_c11", {31'b0, busy_o}, '0);
    issue(32'd9, 32'd3, 1'b0, 1'b1, acc);
    drain();

    // Annul in END is ignored: write still occurs
    run_op(32'd77, 32'd5, 1'b0, acc);
    wait_until(acc + W + 1);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    drain();

    // Asynchronous reset mid-ON
    wait_free();
    issue(32'd100, 32'd7, 1'b0, 1'b0, acc);
    wait_until(acc + 15);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy_o}, '0);
    chk("arst_ready", {31'b0, ready_o}, '0);
    chk("arst_we", {31'b0, hilo_we_o}, '0);
    chk("arst_hi", hi_o, '0);
    chk("arst_lo", lo_o, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(32'd10, 32'd3, 1'b0, acc);
    drain();

    // Signed overflow followed by a back-to-back start
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    run_op(32'hFFFF_FFFF, 32'h0000_0010, 1'b1, acc);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);
    run_op(32'h8000_0000, 32'h0000_0003, 1'b1, acc);

    // Randomized operations, queued back-to-back
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(a, b, s, acc);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
